run_before_encoder: RTL and testbench
=====================================

Name: run_before_encoder

Overview:
- Encoder for the CAVLC run_before syntax element. It is the transmit-side counterpart of the run_before decode table.
- Per 4x4 block it accepts TotalZeros and TotalCoeff, then a stream of run_before values ordered from the highest-frequency coefficient downward.
- It tracks zerosLeft and emits one left-aligned variable-length codeword per coded run to the bitstream packer over a valid/ready interface.
- Runs that are not coded (zerosLeft already 0, or the last coefficient) never reach the output.

Parameters:
- CODE_W, 11, codeword field width; the MSB of the code sits in bit CODE_W-1.

Ports:
- Clk  input  1  single clock.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle block start; samples TotalZeros and TotalCoeff; honoured only in IDLE.
- TotalZeros  input  4  total zeros before the last nonzero coefficient (0..15).
- TotalCoeff  input  5  nonzero coefficient count (0..16).
- RunValid  input  1  RunBefore is valid.
- RunReady  output  1  encoder accepts RunBefore this cycle.
- RunBefore  input  4  run_before of the current coefficient (0..14).
- CodeValid  output  1  Code and CodeLen are valid.
- CodeReady  input  1  downstream accepts the codeword.
- Code  output  CODE_W  codeword, left-aligned, MSB at bit 10, unused bits 0.
- CodeLen  output  4  codeword length, 1..11.
- ZeroesLeft  output  4  current zerosLeft (status).
- Busy  output  1  high in any state except IDLE.
- Done  output  1  one-cycle pulse when the block completes.
- Error  output  1  sticky; set when RunBefore > zerosLeft; cleared on Start or Rst.

Behaviour:
- Reset: state IDLE, RunReady=0, CodeValid=0, Code=0, CodeLen=0, ZeroesLeft=0, Busy=0, Done=0, Error=0, runsLeft=0.
- States are IDLE, RUN and DRAIN.
- IDLE, on Start:
  - zerosLeft←TotalZeros; runsLeft←max(TotalCoeff-1, 0); Error←0.
  - If runsLeft==0, go to DRAIN with no output, which yields Done the next cycle.
  - Otherwise go to RUN.
  - Start in any other state is ignored.
- RUN handshake:
  - RunReady = (state==RUN) && (zerosLeft==0 || !CodeValid || CodeReady).
  - A run is consumed when RunValid && RunReady.
- Consumed run with zerosLeft>0 and RunBefore<=zerosLeft:
  - Register Code/CodeLen from the table using the pre-update zerosLeft; CodeValid←1.
  - zerosLeft←zerosLeft-RunBefore; runsLeft←runsLeft-1.
- Consumed run with zerosLeft==0: no codeword is produced; runsLeft decrements. RunBefore≠0 in this case sets Error.
- Consumed run with RunBefore>zerosLeft: Error←1; no codeword; zerosLeft←0; runsLeft decrements.
- CodeValid clears on CodeValid&&CodeReady unless a new code is loaded in the same cycle. Back-to-back throughput is one code per cycle.
- When runsLeft reaches 0 on a consume, go to DRAIN.
- DRAIN: wait until CodeValid==0 (or is being accepted), then pulse Done for one cycle and return to IDLE.
- Code/CodeLen hold their value while CodeValid && !CodeReady.
- Code table (codes left-aligned; zL = zerosLeft, r = RunBefore):
  - zL=1: r0 "1", r1 "0".
  - zL=2: r0 "1", r1 "01", r2 "00".
  - zL=3: r0 "11", r1 "10", r2 "01", r3 "00".
  - zL=4: r0 "11", r1 "10", r2 "01", r3 "001", r4 "000".
  - zL=5: r0 "11", r1 "10", r2 "011", r3 "010", r4 "001", r5 "000".
  - zL=6: r0 "11", r1 "000", r2 "001", r3 "011", r4 "010", r5 "101", r6 "100".
  - zL>=7, r0..6: "111", "110", "101", "100", "011", "010", "001".
  - zL>=7, r7..14: r leading zeros minus 4, then a 1. r7="0001" (len 4), r8 len 5, and so on up to r14="00000000001" (len 11).
- Round trip: decoding Code with the decode table at the same zerosLeft must return RunBefore and a shift equal to CodeLen.
- Rst in any state returns to IDLE within that edge. An in-flight codeword is discarded and no Done is produced.

Test Plan:
- Basic block: Start TotalZeros=3, TotalCoeff=4; runs 1,0,2 with CodeReady=1.
  - Codes (Code/CodeLen): 11'b10000000000/2, 11'b10000000000/1, 11'b00000000000/2.
  - ZeroesLeft 3→2→2→0; Done one cycle after the last accept.
- Long code: TotalZeros=14, TotalCoeff=2; run 14 → Code=11'b00000000001, CodeLen=11, Done.
- Early termination: TotalZeros=2, TotalCoeff=5; runs 2,0,0,0 → exactly one code "00"/2; the remaining three runs are consumed with no CodeValid; Done; Error=0.
- Backpressure: zL=6 block with runs 5,1 and CodeReady low for 4 cycles.
  - Code "101"/3 is held stable and RunReady=0 throughout.
  - On release, next code is zL=1, r1 → "0"/1.
- Degenerate and error cases:
  - TotalCoeff=1: Done 2 cycles after Start, no codes.
  - TotalZeros=3 with run 5: Error=1 and no code; Error stays high until the next Start.
- Reset mid-block: assert Rst while CodeValid=1 → next cycle all outputs at reset values, no Done; a following Start operates normally.

Source files
------------

// File: rtl/run_before_encoder_if.sv
// Bundles the block setup, the run_before stream, the codeword stream and the
// status outputs of the CAVLC run_before encoder.
interface run_before_encoder_if #(
    parameter int CODE_W = 11
);
    logic              start;
    logic [3:0]        total_zeros;
    logic [4:0]        total_coeff;
    logic              run_valid;
    logic              run_ready;
    logic [3:0]        run_before;
    logic              code_valid;
    logic              code_ready;
    logic [CODE_W-1:0] code;
    logic [3:0]        code_len;
    logic [3:0]        zeroes_left;
    logic              busy;
    logic              done;
    logic              error;

    // Upstream side: supplies block parameters and runs, sinks codewords.
    modport master (
        output start, total_zeros, total_coeff, run_valid, run_before, code_ready,
        input  run_ready, code_valid, code, code_len, zeroes_left, busy, done, error
    );

    // Encoder side.
    modport slave (
        input  start, total_zeros, total_coeff, run_valid, run_before, code_ready,
        output run_ready, code_valid, code, code_len, zeroes_left, busy, done, error
    );
endinterface

// File: rtl/run_before_encoder.sv
// CAVLC run_before encoder: walks zerosLeft over a 4x4 block's runs and emits one
// left-aligned VLC codeword per coded run over a valid/ready stream.
module run_before_encoder #(
    parameter int CODE_W = 11
) (
    input logic           clk,
    input logic           rst,
    run_before_encoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [CODE_W-1:0] bits;
        logic [3:0]        len;
    } code_t;

    state_t     state, state_next;
    logic [3:0] zeros_left;
    logic [4:0] runs_left;
    logic       code_valid;
    code_t      code_q;
    code_t      code_next;
    logic       done;
    logic       error;

    logic run_ready;
    logic drain_ok;
    logic consume;
    logic coded;
    logic bad;

    // Right-aligned value/length from the run_before table, then left-aligned.
    function automatic code_t lookup(input logic [3:0] zl, input logic [3:0] r);
        logic [2:0] v;
        logic [3:0] len;
        code_t      c;
        v   = 3'd0;
        len = 4'd1;
        case (zl)
            4'd1: begin
                v   = (r == 4'd0) ? 3'd1 : 3'd0;
                len = 4'd1;
            end
            4'd2: begin
                v   = (r == 4'd2) ? 3'd0 : 3'd1;
                len = (r == 4'd0) ? 4'd1 : 4'd2;
            end
            4'd3: begin
                v   = 3'(4'd3 - r);
                len = 4'd2;
            end
            4'd4: begin
                v   = (r <= 4'd2) ? 3'(4'd3 - r) : 3'(4'd4 - r);
                len = (r <= 4'd2) ? 4'd2 : 4'd3;
            end
            4'd5: begin
                v   = (r <= 4'd1) ? 3'(4'd3 - r) : 3'(4'd5 - r);
                len = (r <= 4'd1) ? 4'd2 : 4'd3;
            end
            4'd6: begin
                len = (r == 4'd0) ? 4'd2 : 4'd3;
                case (r)
                    4'd0:    v = 3'd3;
                    4'd1:    v = 3'd0;
                    4'd2:    v = 3'd1;
                    4'd3:    v = 3'd3;
                    4'd4:    v = 3'd2;
                    4'd5:    v = 3'd5;
                    default: v = 3'd4;
                endcase
            end
            default: begin
                // zerosLeft >= 7: fixed 3-bit codes, then a unary-style escape.
                v   = (r <= 4'd6) ? 3'(4'd7 - r) : 3'd1;
                len = (r <= 4'd6) ? 4'd3 : 4'(r - 4'd3);
            end
        endcase
        c.len  = len;
        c.bits = CODE_W'(v) << (CODE_W - int'(len));
        return c;
    endfunction

    assign drain_ok  = !code_valid || bus.code_ready;
    assign consume   = bus.run_valid && run_ready;
    assign bad       = consume && (bus.run_before > zeros_left);
    assign coded     = consume && (zeros_left != 4'd0) && !bad;
    assign code_next = lookup(zeros_left, bus.run_before);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would infer a latch.
        state_next = state;
        run_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start)
                    state_next = (bus.total_coeff <= 5'd1) ? DRAIN : RUN;
            end
            RUN: begin
                // A run that cannot produce a code may bypass a stalled output.
                run_ready = (zeros_left == 4'd0) || drain_ok;
                if (bus.run_valid && run_ready && runs_left == 5'd1)
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_ok) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zeros_left <= 4'd0;
            runs_left  <= 5'd0;
            code_valid <= 1'b0;
            code_q     <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= (state == DRAIN) && drain_ok;

            if (state == IDLE && bus.start) begin
                zeros_left <= bus.total_zeros;
                runs_left  <= (bus.total_coeff == 5'd0) ? 5'd0 : bus.total_coeff - 5'd1;
                error      <= 1'b0;
            end

            if (consume) begin
                runs_left <= runs_left - 5'd1;
                if (bad) begin
                    error      <= 1'b1;
                    zeros_left <= 4'd0;
                end else if (zeros_left != 4'd0) begin
                    zeros_left <= zeros_left - bus.run_before;
                end
            end

            if (coded) begin
                code_valid <= 1'b1;
                code_q     <= code_next;
            end else if (code_valid && bus.code_ready) begin
                code_valid <= 1'b0;
            end
        end
    end

    assign bus.run_ready   = run_ready;
    assign bus.code_valid  = code_valid;
    assign bus.code        = code_q.bits;
    assign bus.code_len    = code_q.len;
    assign bus.zeroes_left = zeros_left;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done;
    assign bus.error       = error;

endmodule

// File: tb/tb_run_before_encoder.sv
// Self-checking bench for run_before_encoder: code-table vectors, hand-written
// handshake/reset sequences and random blocks against a string-table model.
module tb_run_before_encoder;

    localparam int CODE_W = 11;

    logic clk;
    logic rst;

    run_before_encoder_if #(.CODE_W(CODE_W)) bus ();

    run_before_encoder #(.CODE_W(CODE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [CODE_W-1:0] got_code[$];
    int                got_len[$];
    int                blk_runs[$];

    typedef struct {
        int                zl;
        int                r;
        logic [CODE_W-1:0] code;
        int                len;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference codeword: bit strings straight from the run_before table.
    function automatic void ref_code(input int zl, input int r,
                                     output logic [CODE_W-1:0] c, output int len);
        string row[7];
        string s;
        case (zl)
            1:       row = '{"1", "0", "", "", "", "", ""};
            2:       row = '{"1", "01", "00", "", "", "", ""};
            3:       row = '{"11", "10", "01", "00", "", "", ""};
            4:       row = '{"11", "10", "01", "001", "000", "", ""};
            5:       row = '{"11", "10", "011", "010", "001", "000", ""};
            6:       row = '{"11", "000", "001", "011", "010", "101", "100"};
            default: row = '{"111", "110", "101", "100", "011", "010", "001"};
        endcase
        if (zl >= 7 && r >= 7) begin
            s = "";
            for (int i = 0; i < r - 4; i++) s = {s, "0"};
            s = {s, "1"};
        end else begin
            s = row[r];
        end
        len = s.len();
        c   = '0;
        for (int i = 0; i < len; i++)
            if (s.substr(i, i) == "1") c[CODE_W-1-i] = 1'b1;
    endfunction

    task automatic start_blk(input int tz, input int tc);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.total_zeros = 4'(tz);
        bus.total_coeff = 5'(tc);
        bus.run_valid   = 1'b0;
        bus.code_ready  = 1'b1;
    endtask

    task automatic step(input logic rv, input logic [3:0] rb, input logic cr);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.run_valid  = rv;
        bus.run_before = rb;
        bus.code_ready = cr;
        #1;
    endtask

    // Runs one block with blk_runs, randomized backpressure and gaps, and
    // compares every accepted codeword plus the final status with the model.
    task automatic run_block(input int tz, input int tc, input int ready_pct, input int gap_pct);
        int                zl;
        int                n;
        int                idx;
        bit                err;
        bit                seen_done;
        logic [CODE_W-1:0] exp_c[$];
        int                exp_l[$];
        logic [CODE_W-1:0] c;
        int                len;

        zl  = tz;
        n   = (tc > 0) ? tc - 1 : 0;
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (blk_runs[i] > zl) begin
                err = 1'b1;
                zl  = 0;
            end else if (zl > 0) begin
                ref_code(zl, blk_runs[i], c, len);
                exp_c.push_back(c);
                exp_l.push_back(len);
                zl -= blk_runs[i];
            end
        end

        got_code.delete();
        got_len.delete();
        idx       = 0;
        seen_done = 1'b0;
        start_blk(tz, tc);
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            @(negedge clk);
            bus.start      = 1'b0;
            bus.code_ready = ($urandom_range(99) < ready_pct);
            if (idx < n && $urandom_range(99) >= gap_pct) begin
                bus.run_valid  = 1'b1;
                bus.run_before = 4'(blk_runs[idx]);
            end else begin
                bus.run_valid  = 1'b0;
                bus.run_before = 4'($urandom_range(15));
            end
            #1;
            if (bus.done) seen_done = 1'b1;
            if (bus.code_valid && bus.code_ready) begin
                got_code.push_back(bus.code);
                got_len.push_back(int'(bus.code_len));
                if (exp_c.size() == 0) begin
                    check("unexpected_code", 32'(bus.code_valid), 32'd0);
                end else begin
                    check("code", 32'(bus.code), 32'(exp_c.pop_front()));
                    check("code_len", 32'(bus.code_len), 32'(exp_l.pop_front()));
                end
            end
            if (bus.run_valid && bus.run_ready) idx++;
        end
        bus.run_valid = 1'b0;
        check("done_seen", 32'(seen_done), 32'd1);
        check("codes_missing", 32'(exp_c.size()), 32'd0);
        check("runs_consumed", 32'(idx), 32'(n));
        check("error_flag", 32'(bus.error), 32'(err));
        check("zeroes_left_end", 32'(bus.zeroes_left), 32'(zl));
        if (!seen_done) begin
            @(negedge clk) rst = 1'b1;
            @(negedge clk) rst = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_run_ready"},   32'(bus.run_ready),   32'd0);
        check({tag, "_code_valid"},  32'(bus.code_valid),  32'd0);
        check({tag, "_code"},        32'(bus.code),        32'd0);
        check({tag, "_code_len"},    32'(bus.code_len),    32'd0);
        check({tag, "_zeroes_left"}, 32'(bus.zeroes_left), 32'd0);
        check({tag, "_busy"},        32'(bus.busy),        32'd0);
        check({tag, "_done"},        32'(bus.done),        32'd0);
        check({tag, "_error"},       32'(bus.error),       32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tz, tc, zl, r, done_cnt;

        vecs = '{
            '{1, 0, 11'b10000000000, 1},
            '{1, 1, 11'b00000000000, 1},
            '{2, 1, 11'b01000000000, 2},
            '{2, 2, 11'b00000000000, 2},
            '{3, 3, 11'b00000000000, 2},
            '{4, 3, 11'b00100000000, 3},
            '{5, 2, 11'b01100000000, 3},
            '{6, 1, 11'b00000000000, 3},
            '{6, 5, 11'b10100000000, 3},
            '{6, 6, 11'b10000000000, 3},
            '{7, 0, 11'b11100000000, 3},
            '{7, 6, 11'b00100000000, 3},
            '{7, 7, 11'b00010000000, 4},
            '{10, 9, 11'b00000100000, 6},
            '{15, 14, 11'b00000000001, 11},
            '{14, 13, 11'b00000000010, 10}
        };

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.total_zeros = 4'd0;
        bus.total_coeff = 5'd0;
        bus.run_valid   = 1'b0;
        bus.run_before  = 4'd0;
        bus.code_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // Code table vectors: one coded run per block.
        for (int i = 0; i < 16; i++) begin
            blk_runs = '{vecs[i].r};
            run_block(vecs[i].zl, 2, 100, 0);
            check("vec_count", 32'(got_code.size()), 32'd1);
            check("vec_code", 32'(got_code.size() > 0 ? got_code[0] : '1), 32'(vecs[i].code));
            check("vec_len", 32'(got_len.size() > 0 ? got_len[0] : -1), 32'(vecs[i].len));
        end

        // Basic block, cycle by cycle.
        start_blk(3, 4);
        step(1'b1, 4'd1, 1'b1);
        check("basic_zl0", 32'(bus.zeroes_left), 32'd3);
        check("basic_ready", 32'(bus.run_ready), 32'd1);
        check("basic_nocode", 32'(bus.code_valid), 32'd0);
        step(1'b1, 4'd0, 1'b1);
        check("basic_c1", {bus.code_valid, bus.code, bus.code_len}, {1'b1, 11'b10000000000, 4'd2});
        check("basic_zl1", 32'(bus.zeroes_left), 32'd2);
        step(1'b1, 4'd2, 1'b1);
        check("basic_c2", {bus.code_valid, bus.code, bus.code_len}, {1'b1, 11'b10000000000, 4'd1});
        check("basic_zl2", 32'(bus.zeroes_left), 32'd2);
        step(1'b0, 4'd0, 1'b1);
        check("basic_c3", {bus.code_valid, bus.code, bus.code_len}, {1'b1, 11'b00000000000, 4'd2});
        check("basic_zl3", 32'(bus.zeroes_left), 32'd0);
        check("basic_no_done_yet", 32'(bus.done), 32'd0);
        step(1'b0, 4'd0, 1'b1);
        check("basic_done", {bus.done, bus.busy, bus.code_valid}, {1'b1, 1'b0, 1'b0});
        step(1'b0, 4'd0, 1'b1);
        check("basic_done_pulse", 32'(bus.done), 32'd0);

        // Long escape code.
        blk_runs = '{14};
        run_block(14, 2, 100, 0);
        check("long_code", 32'(got_code.size() > 0 ? got_code[0] : '0), 32'(11'b00000000001));
        check("long_len", 32'(got_len.size() > 0 ? got_len[0] : 0), 32'd11);

        // Early termination: zerosLeft hits 0 after the first run.
        blk_runs = '{2, 0, 0, 0};
        run_block(2, 5, 100, 0);
        check("early_count", 32'(got_code.size()), 32'd1);
        check("early_error", 32'(bus.error), 32'd0);

        // Backpressure: code held while the consumer stalls.
        start_blk(6, 3);
        step(1'b1, 4'd5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 4'd1, 1'b0);
            check("bp_run_ready", 32'(bus.run_ready), 32'd0);
            check("bp_hold", {bus.code_valid, bus.code, bus.code_len}, {1'b1, 11'b10100000000, 4'd3});
        end
        step(1'b1, 4'd1, 1'b1);
        check("bp_release_ready", 32'(bus.run_ready), 32'd1);
        step(1'b0, 4'd0, 1'b1);
        check("bp_second", {bus.code_valid, bus.code, bus.code_len}, {1'b1, 11'b00000000000, 4'd1});
        check("bp_zl", 32'(bus.zeroes_left), 32'd0);
        step(1'b0, 4'd0, 1'b1);
        check("bp_done", 32'(bus.done), 32'd1);

        // TotalCoeff=1: no runs, Done two cycles after Start.
        start_blk(5, 1);
        step(1'b0, 4'd0, 1'b1);
        check("tc1_busy", {bus.busy, bus.done}, {1'b1, 1'b0});
        step(1'b0, 4'd0, 1'b1);
        check("tc1_done", {bus.done, bus.code_valid, bus.busy}, {1'b1, 1'b0, 1'b0});
        check("tc1_zl", 32'(bus.zeroes_left), 32'd5);

        // Over-long run: sticky error until the next Start.
        blk_runs = '{5};
        run_block(3, 2, 100, 0);
        check("err_nocode", 32'(got_code.size()), 32'd0);
        repeat (3) step(1'b0, 4'd0, 1'b1);
        check("err_sticky", 32'(bus.error), 32'd1);
        start_blk(2, 2);
        step(1'b0, 4'd0, 1'b1);
        check("err_cleared", 32'(bus.error), 32'd0);
        step(1'b1, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        check("err_next_done", 32'(bus.done), 32'd1);

        // Reset with a codeword in flight.
        start_blk(7, 4);
        step(1'b1, 4'd3, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        check("rst_inflight", 32'(bus.code_valid), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'd0, 1'b1);
            if (bus.done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        blk_runs = '{3, 2, 1};
        run_block(7, 4, 100, 0);
        check("midrst_after_count", 32'(got_code.size()), 32'd3);

        // Random blocks, mostly legal runs with occasional over-long ones.
        for (int b = 0; b < 40; b++) begin
            tz = $urandom_range(15);
            tc = $urandom_range(16);
            zl = tz;
            blk_runs.delete();
            for (int i = 0; i < ((tc > 0) ? tc - 1 : 0); i++) begin
                if ($urandom_range(9) == 0) r = $urandom_range(14);
                else                        r = (zl == 0) ? 0 : $urandom_range(zl);
                blk_runs.push_back(r);
                zl = (r <= zl) ? zl - r : 0;
            end
            run_block(tz, tc, $urandom_range(30, 100), $urandom_range(0, 30));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
